// File: rtl/key_event_fifo_pkg.sv
// rtl/key_event_fifo_pkg.sv - shared key-code and FIFO sizing definitions for the key event path
package key_event_fifo_pkg;

  localparam int KEY_W_DEF    = 4;
  localparam int NUM_KEYS_DEF = 9;
  localparam int DEPTH_DEF    = 4;
  localparam int DROP_W_DEF   = 8;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic key_in_range(input int unsigned code, input int unsigned num_keys);
    return code < num_keys;
  endfunction

endpackage

// File: rtl/key_event_fifo_sync_fifo.sv
// rtl/key_event_fifo_sync_fifo.sv - flop-based first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = KEY_W_DEF,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);

  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - synchronises keypad level outputs into press events and queues them
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int KEY_W    = KEY_W_DEF,
  parameter int NUM_KEYS = NUM_KEYS_DEF,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_key,
  input  logic [KEY_W-1:0]         key,
  output logic                     evt_valid,
  output logic [KEY_W-1:0]         evt_key,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic             v_s1, v_s2, v_s3;
  logic [KEY_W-1:0] k_s1, k_s2;
  logic [1:0]       fill;
  logic             armed;
  logic             rise, in_range, req, pop, push, full, empty, lost, bad;

  // fill marks when v_s2 holds a real post-reset sample; armed needs a real low first,
  // so a press held across reset release never becomes an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_s1  <= 1'b0;
      v_s2  <= 1'b0;
      v_s3  <= 1'b0;
      k_s1  <= '0;
      k_s2  <= '0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      v_s1 <= valid_key;
      v_s2 <= v_s1;
      v_s3 <= v_s2;
      k_s1 <= key;
      k_s2 <= k_s1;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !v_s2) armed <= 1'b1;
    end
  end

  assign rise     = v_s2 & ~v_s3 & armed;
  assign in_range = key_in_range(32'(k_s2), NUM_KEYS);
  assign req      = rise & in_range;
  assign bad      = rise & ~in_range;
  assign pop      = evt_valid & evt_ready;
  assign push     = req & (~full | pop);
  assign lost     = req & full & ~pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (k_s2),
    .pop   (pop),
    .rdata (evt_key),
    .full  (full),
    .empty (empty),
    .count (occupancy)
  );

  assign evt_valid = ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (lost) overflow <= 1'b1;
      if ((lost || bad) && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - randomised and directed self-checking bench for key_event_fifo
module tb_key_event_fifo;

  localparam int DEPTH    = 4;
  localparam int NUM_KEYS = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_key = 1'b0;
  logic [3:0] key = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_key;
  logic [2:0] occupancy;
  logic       overflow;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .valid_key (valid_key),
    .key       (key),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_ready (evt_ready),
    .occupancy (occupancy),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an event is a real low sample followed by a high sample, pushed two edges later.
  int         q[$];
  bit         m_ovf;
  int         m_drop;
  int         nedge;
  bit         h0, h1, h2;
  logic [3:0] hk0, hk1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 0; m_drop = 0; nedge = 0;
      h0 = 0; h1 = 0; h2 = 0; hk0 = '0; hk1 = '0;
    end else begin
      bit req;
      bit do_pop;
      nedge++;
      req    = (nedge >= 4) && h1 && !h2;
      do_pop = (q.size() > 0) && evt_ready;
      if (do_pop) void'(q.pop_front());
      if (req) begin
        if (int'(hk1) >= NUM_KEYS) begin
          if (m_drop < 255) m_drop++;
        end else if (q.size() < DEPTH) begin
          q.push_back(int'(hk1));
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      h2 = h1; h1 = h0; h0 = valid_key;
      hk1 = hk0; hk0 = key;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_evt_valid", evt_valid, 0);
      check("rst_evt_key", evt_key, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_cnt", drop_cnt, 0);
    end else begin
      check("evt_valid", evt_valid, q.size() > 0);
      check("evt_key", evt_key, q.size() > 0 ? q[0] : 0);
      check("occupancy", occupancy, q.size());
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    key = k;
    valid_key = 1'b1;
    cyc(hold);
    valid_key = 1'b0;
    cyc(gap);
  endtask

  initial begin
    int exp_order[4];
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_key = 1'($urandom_range(0, 1));
      key       = 4'($urandom_range(0, 15));
      evt_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    check("lit_reset_valid", evt_valid, 0);
    check("lit_reset_drop", drop_cnt, 0);

    evt_ready = 1'b0;
    key = 4'd3;
    valid_key = 1'b1;
    reset = 1'b1;
    cyc(10);
    check("lit_held_no_event", evt_valid, 0);
    check("lit_held_occ", occupancy, 0);
    valid_key = 1'b0;
    cyc(5);

    key = 4'd5;
    valid_key = 1'b1;
    cyc(2);
    check("lit_latency_before", evt_valid, 0);
    cyc(1);
    check("lit_latency_valid", evt_valid, 1);
    check("lit_latency_key", evt_key, 5);
    cyc(17);
    check("lit_single_event", occupancy, 1);
    evt_ready = 1'b1;
    cyc(1);
    check("lit_pop_empty", evt_valid, 0);
    check("lit_pop_occ", occupancy, 0);
    evt_ready = 1'b0;
    valid_key = 1'b0;
    cyc(5);

    for (int k = 1; k <= 4; k++) press(4'(k), 4, 4);
    check("lit_bp_occ", occupancy, 4);
    check("lit_bp_head", evt_key, 1);

    press(4'd7, 4, 4);
    check("lit_ovf_flag", overflow, 1);
    check("lit_ovf_drop", drop_cnt, 1);
    check("lit_ovf_head", evt_key, 1);

    key = 4'd8;
    valid_key = 1'b1;
    cyc(2);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    cyc(2);
    valid_key = 1'b0;
    cyc(4);
    check("lit_simul_occ", occupancy, 4);
    check("lit_simul_drop", drop_cnt, 1);
    exp_order = '{2, 3, 4, 8};
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("lit_drain_order", evt_key, exp_order[i]);
      cyc(1);
    end
    evt_ready = 1'b0;
    check("lit_drained_occ", occupancy, 0);
    check("lit_ovf_sticky", overflow, 1);

    press(4'd12, 4, 4);
    check("lit_oor_no_event", evt_valid, 0);
    check("lit_oor_drop", drop_cnt, 2);
    for (int i = 0; i < 300; i++) press(4'd12, 2, 2);
    check("lit_drop_saturate", drop_cnt, 255);

    press(4'd1, 3, 3);
    press(4'd2, 3, 3);
    key = 4'd6;
    valid_key = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
    check("lit_midrst_occ", occupancy, 0);
    check("lit_midrst_drop", drop_cnt, 0);
    cyc(3);
    reset = 1'b1;
    cyc(8);
    check("lit_midrst_no_event", evt_valid, 0);
    valid_key = 1'b0;
    cyc(4);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) valid_key = ~valid_key;
      if ($urandom_range(0, 4) == 0) key = 4'($urandom_range(0, 9));
      evt_ready = ($urandom_range(0, 2) == 0);
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
